// File: rtl/ps2_key_decoder.sv
// PS/2 scancode stream to player direction command codes and start pulse.
// Handles E0/F0 prefixes, drops repeats and reversals per player.
module ps2_key_decoder #(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [4:0] IDLE_CODE      = 5'd31
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_byte_valid,
    input  logic       enable,
    output logic [4:0] KEY_PRESSED,
    output logic       key_valid,
    output logic       start_pulse,
    output logic [7:0] suppressed_count
);

    localparam int             CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_tcnt;
    logic            w_timeout;
    logic            w_dec;
    logic            w_dec_ext;
    logic            w_hit;
    logic            w_space;
    logic [1:0]      w_p;
    logic [1:0]      w_n;
    logic [1:0]      w_dp;
    logic            w_rev;
    logic            w_drop;
    logic            w_emit;
    logic            w_supp;
    logic [3:0][1:0] r_dir;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dec       = 1'b0;
        w_dec_ext   = 1'b0;
        w_timeout   = (r_state != S_IDLE) && (r_tcnt == TMAX);
        if (ps2_byte_valid) begin
            unique case (r_state)
                S_IDLE: begin
                    if (ps2_byte == 8'hE0) begin
                        w_state_nxt = S_EXT;
                    end else if (ps2_byte == 8'hF0) begin
                        w_state_nxt = S_BRK;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                S_EXT: begin
                    if (ps2_byte == 8'hF0) begin
                        w_state_nxt = S_EXT_BRK;
                    end else if (ps2_byte != 8'hE0) begin
                        w_dec       = 1'b1;
                        w_dec_ext   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (ps2_byte == 8'hE0) begin
                        w_state_nxt = S_EXT_BRK;
                    end else if (ps2_byte != 8'hF0) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_EXT_BRK: begin
                    if (ps2_byte != 8'hF0) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Quiet-cycle counter only runs while a prefix is pending.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_tcnt <= '0;
        end else if (ps2_byte_valid || r_state == S_IDLE || w_timeout) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    always_comb begin
        w_hit   = 1'b0;
        w_space = 1'b0;
        w_p     = 2'd0;
        w_n     = 2'd0;
        if (w_dec && w_dec_ext) begin
            case (ps2_byte)
                8'h75: begin w_hit = 1'b1; w_p = 2'd1; w_n = 2'd0; end
                8'h72: begin w_hit = 1'b1; w_p = 2'd1; w_n = 2'd1; end
                8'h6B: begin w_hit = 1'b1; w_p = 2'd1; w_n = 2'd2; end
                8'h74: begin w_hit = 1'b1; w_p = 2'd1; w_n = 2'd3; end
                default: ;
            endcase
        end else if (w_dec) begin
            case (ps2_byte)
                8'h1D: begin w_hit = 1'b1; w_p = 2'd0; w_n = 2'd0; end
                8'h1B: begin w_hit = 1'b1; w_p = 2'd0; w_n = 2'd1; end
                8'h1C: begin w_hit = 1'b1; w_p = 2'd0; w_n = 2'd2; end
                8'h23: begin w_hit = 1'b1; w_p = 2'd0; w_n = 2'd3; end
                8'h43: begin w_hit = 1'b1; w_p = 2'd2; w_n = 2'd0; end
                8'h42: begin w_hit = 1'b1; w_p = 2'd2; w_n = 2'd1; end
                8'h3B: begin w_hit = 1'b1; w_p = 2'd2; w_n = 2'd2; end
                8'h4B: begin w_hit = 1'b1; w_p = 2'd2; w_n = 2'd3; end
                8'h75: begin w_hit = 1'b1; w_p = 2'd3; w_n = 2'd0; end
                8'h73: begin w_hit = 1'b1; w_p = 2'd3; w_n = 2'd1; end
                8'h6B: begin w_hit = 1'b1; w_p = 2'd3; w_n = 2'd2; end
                8'h74: begin w_hit = 1'b1; w_p = 2'd3; w_n = 2'd3; end
                8'h29: w_space = 1'b1;
                default: ;
            endcase
        end
    end

    // Reversal: same axis (bit 1) but opposite sense (bit 0).
    assign w_dp   = r_dir[w_p];
    assign w_rev  = (w_n[1] == w_dp[1]) && (w_n[0] != w_dp[0]);
    assign w_drop = !enable || (w_n == w_dp) || w_rev;
    assign w_emit = w_hit && !w_drop;
    assign w_supp = w_hit && w_drop;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            KEY_PRESSED      <= IDLE_CODE;
            key_valid        <= 1'b0;
            start_pulse      <= 1'b0;
            suppressed_count <= 8'd0;
            r_dir            <= {2'b11, 2'b10, 2'b01, 2'b00};
        end else begin
            KEY_PRESSED <= w_emit ? {1'b0, w_p, w_n} : IDLE_CODE;
            key_valid   <= w_emit;
            start_pulse <= w_space;
            if (w_supp && suppressed_count != 8'hFF) begin
                suppressed_count <= suppressed_count + 8'd1;
            end
            if (w_emit) begin
                r_dir[w_p] <= w_n;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus random bytes
// compared cycle by cycle with a prefix-flag reference model.
module tb_ps2_key_decoder;

    localparam int T = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ps2_byte;
    logic       ps2_byte_valid;
    logic       enable;
    logic [4:0] KEY_PRESSED;
    logic       key_valid;
    logic       start_pulse;
    logic [7:0] suppressed_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES(T),
        .IDLE_CODE     (5'd31)
    ) dut (
        .CLOCK_50        (clk),
        .reset           (reset),
        .ps2_byte        (ps2_byte),
        .ps2_byte_valid  (ps2_byte_valid),
        .enable          (enable),
        .KEY_PRESSED     (KEY_PRESSED),
        .key_valid       (key_valid),
        .start_pulse     (start_pulse),
        .suppressed_count(suppressed_count)
    );

    logic [7:0] nx_tab [12] = '{8'h1D, 8'h1B, 8'h1C, 8'h23,
                                8'h43, 8'h42, 8'h3B, 8'h4B,
                                8'h75, 8'h73, 8'h6B, 8'h74};
    int         nx_ply [12] = '{0, 0, 0, 0, 2, 2, 2, 2, 3, 3, 3, 3};
    logic [7:0] ex_tab [4]  = '{8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] pool   [16] = '{8'h1D, 8'h1B, 8'h1C, 8'h23,
                                8'h43, 8'h42, 8'h3B, 8'h4B,
                                8'h75, 8'h73, 8'h6B, 8'h74,
                                8'h72, 8'h29, 8'hE0, 8'hF0};

    bit m_ext, m_brk;
    int m_quiet;
    int m_dir [4];
    int m_cnt;
    int e_code, e_kv, e_sp;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_quiet = 0; m_cnt = 0;
        for (int i = 0; i < 4; i++) m_dir[i] = i;
        e_code = 31; e_kv = 0; e_sp = 0;
    endtask

    task automatic model_make(bit ext, logic [7:0] b, bit en);
        int p, n;
        p = -1;
        n = 0;
        if (!ext && b == 8'h29) begin
            e_sp = 1;
            return;
        end
        for (int i = 0; i < 12; i++)
            if (!ext && nx_tab[i] == b) begin p = nx_ply[i]; n = i % 4; end
        for (int i = 0; i < 4; i++)
            if (ext && ex_tab[i] == b) begin p = 1; n = i; end
        if (p < 0) return;
        if (!en || n == m_dir[p] || (n ^ m_dir[p]) == 1) begin
            if (m_cnt < 255) m_cnt++;
        end else begin
            e_code = p * 4 + n;
            e_kv = 1;
            m_dir[p] = n;
        end
    endtask

    task automatic model_cycle(bit v, logic [7:0] b, bit en);
        e_code = 31; e_kv = 0; e_sp = 0;
        if (!v) begin
            if (m_ext || m_brk) begin
                m_quiet++;
                if (m_quiet == T) begin m_ext = 0; m_brk = 0; m_quiet = 0; end
            end
        end else begin
            m_quiet = 0;
            if (m_brk) begin
                if (b == 8'hF0) ;
                else if (b == 8'hE0 && !m_ext) m_ext = 1;
                else begin m_ext = 0; m_brk = 0; end
            end else if (b == 8'hF0) m_brk = 1;
            else if (b == 8'hE0) m_ext = 1;
            else begin
                model_make(m_ext, b, en);
                m_ext = 0;
            end
        end
    endtask

    task automatic step(bit v, logic [7:0] b, bit en);
        @(negedge clk);
        ps2_byte_valid = v;
        ps2_byte       = b;
        enable         = en;
        model_cycle(v, b, en);
        @(posedge clk);
        #1;
        chk("code", KEY_PRESSED, e_code);
        chk("kv", key_valid, e_kv);
        chk("sp", start_pulse, e_sp);
        chk("cnt", suppressed_count, m_cnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ps2_byte_valid = 1'b0;
        model_reset();
        #1;
        chk("rst_code", KEY_PRESSED, 31);
        chk("rst_kv", key_valid, 0);
        chk("rst_sp", start_pulse, 0);
        chk("rst_cnt", suppressed_count, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic mid_reset();
        reset = 1'b1;
        #1;
        chk("mrst_code", KEY_PRESSED, 31);
        chk("mrst_kv", key_valid, 0);
        chk("mrst_sp", start_pulse, 0);
        chk("mrst_cnt", suppressed_count, 0);
        @(negedge clk);
        reset = 1'b0;
        ps2_byte_valid = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1;
        ps2_byte = 8'h00;
        ps2_byte_valid = 1'b0;
        enable = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        do_reset();

        step(1, 8'h1C, 1); chk("a_1c_code", KEY_PRESSED, 2);
        step(1, 8'h23, 1); chk("a_23_cnt", suppressed_count, 1);
        chk("a_23_kv", key_valid, 0);
        step(1, 8'hE0, 1);
        step(1, 8'h6B, 1); chk("a_e06b", KEY_PRESSED, 6);
        step(1, 8'h6B, 1); chk("a_6b_cnt", suppressed_count, 2);
        step(0, 8'h00, 1); chk("a_hold", key_valid, 0);

        do_reset();
        step(1, 8'h1D, 1); chk("b_rep_cnt", suppressed_count, 1);
        step(1, 8'h1C, 1); chk("b_1c", KEY_PRESSED, 2);
        step(1, 8'h1D, 1); chk("b_1d", KEY_PRESSED, 0);
        step(1, 8'h1D, 1); chk("b_rep2", suppressed_count, 2);

        do_reset();
        step(1, 8'hF0, 1); step(1, 8'h1C, 1);
        step(1, 8'hE0, 1); step(1, 8'hF0, 1); step(1, 8'h75, 1);
        chk("c_brk_kv", key_valid, 0);
        step(1, 8'h43, 1); chk("c_43", KEY_PRESSED, 8);

        do_reset();
        step(1, 8'hE0, 1);
        repeat (T - 1) step(0, 8'h00, 1);
        step(1, 8'h6B, 1); chk("d_ext_edge", KEY_PRESSED, 6);
        step(1, 8'hE0, 1);
        repeat (T) step(0, 8'h00, 1);
        step(1, 8'h75, 1); chk("d_timeout", KEY_PRESSED, 12);

        do_reset();
        step(1, 8'h29, 0); chk("e_space", start_pulse, 1);
        step(0, 8'h00, 0); chk("e_space_off", start_pulse, 0);
        step(1, 8'hE0, 0); step(1, 8'h29, 0);
        chk("e_ext29", start_pulse, 0);
        step(1, 8'h1C, 0); chk("e_dis", suppressed_count, 1);
        repeat (300) step(1, 8'h1C, 0);
        chk("e_sat", suppressed_count, 255);
        step(1, 8'h29, 0);
        mid_reset();
        step(1, 8'hE0, 1);
        mid_reset();
        step(1, 8'h75, 1); chk("e_rst_prefix", KEY_PRESSED, 12);

        do_reset();
        for (int it = 0; it < 3000; it++) begin
            int r;
            logic [7:0] b;
            bit en;
            r  = $urandom_range(0, 99);
            en = ($urandom_range(0, 9) != 0);
            if (r < 4) begin
                repeat ($urandom_range(1, T + 5)) step(0, 8'h00, en);
            end else if (r < 14) begin
                step(0, 8'h00, en);
            end else begin
                if (r < 20) b = 8'($urandom_range(0, 255));
                else b = pool[$urandom_range(0, 15)];
                step(1, b, en);
            end
        end

        @(negedge clk);
        ps2_byte_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
